cpu_boot_sequencer: RTL

//  Hardware replacement for bench-side memory preloading plus a fixed run window for the single-cycle CPU.

---
 rtl/cpu_boot_sequencer.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/cpu_boot_sequencer.sv
// rtl/cpu_boot_sequencer.sv - stream loader for register bank / instruction memory plus bounded CPU run window
module cpu_boot_sequencer #(
   parameter int DATA_W   = 32,
   parameter int RF_DEPTH = 32,
   parameter int IM_DEPTH = 64,
   parameter int RUN_W    = 16,
   localparam int RF_AW   = $clog2(RF_DEPTH),
   localparam int IM_AW   = $clog2(IM_DEPTH)
) (
   input  logic              clk_CPU,
   input  logic              rst_n,
   input  logic              start,
   input  logic              abort,
   input  logic [RUN_W-1:0]  run_len,
   input  logic              ld_valid,
   output logic              ld_ready,
   input  logic [DATA_W-1:0] ld_data,
   input  logic              ld_sel,
   input  logic              ld_last,
   output logic              rf_we,
   output logic [RF_AW-1:0]  rf_addr,
   output logic [DATA_W-1:0] rf_wdata,
   output logic              im_we,
   output logic [IM_AW-1:0]  im_addr,
   output logic [DATA_W-1:0] im_wdata,
   output logic              cpu_rst_n,
   output logic              busy,
   output logic              done,
   output logic              ovf_err
);

   // Counters are one bit wider than the address so they can sit at DEPTH
   // (memory full) without wrapping back onto entry 0.
   localparam int RF_CW = RF_AW + 1;
   localparam int IM_CW = IM_AW + 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_LOAD,
      S_RUN,
      S_DONE
   } state_t;

   state_t            state;
   state_t            state_nxt;
   logic [RF_CW-1:0]  rf_cnt;
   logic [IM_CW-1:0]  im_cnt;
   logic [RUN_W-1:0]  run_len_q;
   logic [RUN_W-1:0]  run_cnt;
   logic              hs;
   logic              load_go;
   logic              rf_full;
   logic              im_full;

   assign hs      = ld_valid & ld_ready;
   assign rf_full = (rf_cnt == RF_CW'(RF_DEPTH));
   assign im_full = (im_cnt == IM_CW'(IM_DEPTH));

   // State register
   always_ff @(posedge clk_CPU or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state and state-decoded outputs; abort overrides every transition
   always_comb begin
      state_nxt = state;
      load_go   = 1'b0;
      ld_ready  = 1'b0;
      cpu_rst_n = 1'b0;
      busy      = 1'b0;
      done      = 1'b0;
      case (state)
         S_IDLE: begin
            if (start) begin
               load_go   = !abort;
               state_nxt = S_LOAD;
            end
         end
         S_LOAD: begin
            ld_ready = 1'b1;
            busy     = 1'b1;
            if (hs && ld_last) begin
               state_nxt = (run_len_q == '0) ? S_DONE : S_RUN;
            end
         end
         S_RUN: begin
            cpu_rst_n = 1'b1;
            busy      = 1'b1;
            // run_cnt counts completed RUN cycles, so this is the last one
            if (run_cnt == run_len_q - RUN_W'(1)) begin
               state_nxt = S_DONE;
            end
         end
         S_DONE: begin
            done = 1'b1;
            if (start) begin
               load_go   = !abort;
               state_nxt = S_LOAD;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
      if (abort) begin
         state_nxt = S_IDLE;
      end
   end

   // Registered write ports, address counters and sticky overflow flag.
   // A handshake taken in the same cycle as abort still produces its write.
   always_ff @(posedge clk_CPU or negedge rst_n) begin
      if (!rst_n) begin
         rf_we     <= 1'b0;
         rf_addr   <= '0;
         rf_wdata  <= '0;
         im_we     <= 1'b0;
         im_addr   <= '0;
         im_wdata  <= '0;
         rf_cnt    <= '0;
         im_cnt    <= '0;
         ovf_err   <= 1'b0;
         run_len_q <= '0;
      end else begin
         rf_we <= 1'b0;
         im_we <= 1'b0;
         if (load_go) begin
            rf_cnt    <= '0;
            im_cnt    <= '0;
            ovf_err   <= 1'b0;
            run_len_q <= run_len;
         end
         if (hs) begin
            if (!ld_sel) begin
               if (rf_full) begin
                  ovf_err <= 1'b1;
               end else begin
                  rf_we    <= 1'b1;
                  rf_addr  <= rf_cnt[RF_AW-1:0];
                  rf_wdata <= ld_data;
                  rf_cnt   <= rf_cnt + RF_CW'(1);
               end
            end else begin
               if (im_full) begin
                  ovf_err <= 1'b1;
               end else begin
                  im_we    <= 1'b1;
                  im_addr  <= im_cnt[IM_AW-1:0];
                  im_wdata <= ld_data;
                  im_cnt   <= im_cnt + IM_CW'(1);
               end
            end
         end
      end
   end

   // Run-window cycle counter; idles at zero outside RUN
   always_ff @(posedge clk_CPU or negedge rst_n) begin
      if (!rst_n) begin
         run_cnt <= '0;
      end else if (state == S_RUN) begin
         run_cnt <= run_cnt + RUN_W'(1);
      end else begin
         run_cnt <= '0;
      end
   end

endmodule
